// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 command constants, sequencer state types and the
// address-window byte helper used by the frame sequencer.
package ssd1306_pkg;

  localparam logic [7:0] DISP_OFF       = 8'hAE;
  localparam logic [7:0] SET_CLK_DIV    = 8'hD5;
  localparam logic [7:0] SET_MUX_RATIO  = 8'hA8;
  localparam logic [7:0] SET_DISP_OFS   = 8'hD3;
  localparam logic [7:0] SET_START_LINE = 8'h40;
  localparam logic [7:0] CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] SET_MEM_MODE   = 8'h20;
  localparam logic [7:0] SEG_REMAP      = 8'hA1;
  localparam logic [7:0] COM_SCAN_DEC   = 8'hC8;
  localparam logic [7:0] SET_COM_PINS   = 8'hDA;
  localparam logic [7:0] SET_CONTRAST   = 8'h81;
  localparam logic [7:0] SET_PRECHARGE  = 8'hD9;
  localparam logic [7:0] SET_VCOM_DESEL = 8'hDB;
  localparam logic [7:0] DISP_RESUME    = 8'hA4;
  localparam logic [7:0] NORM_DISP      = 8'hA6;
  localparam logic [7:0] DISP_ON        = 8'hAF;
  localparam logic [7:0] SET_COL_ADDR   = 8'h21;
  localparam logic [7:0] SET_PAGE_ADDR  = 8'h22;

  localparam int INIT_LEN = 25;
  localparam int WIN_LEN  = 6;

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_INIT,
    ST_READY,
    ST_WIN,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_FDONE
  } seq_state_e;

  typedef enum logic [1:0] {
    HS_ISSUE,
    HS_ACK,
    HS_DONE
  } hs_phase_e;

  // Column window 0..last_col, page window 0..last_page.
  function automatic logic [7:0] win_byte(input logic [2:0] idx,
                                          input logic [7:0] last_col,
                                          input logic [7:0] last_page);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = SET_COL_ADDR;
      3'd2:    b = last_col;
      3'd3:    b = SET_PAGE_ADDR;
      3'd5:    b = last_page;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ssd1306_init_rom.sv
// Power-up command list for a 128x64 SSD1306 panel with internal charge pump.
module ssd1306_init_rom
  import ssd1306_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      5'd0:    data = DISP_OFF;
      5'd1:    data = SET_CLK_DIV;
      5'd2:    data = 8'h80;
      5'd3:    data = SET_MUX_RATIO;
      5'd4:    data = 8'h3F;
      5'd5:    data = SET_DISP_OFS;
      5'd6:    data = 8'h00;
      5'd7:    data = SET_START_LINE;
      5'd8:    data = CHARGE_PUMP;
      5'd9:    data = 8'h14;
      5'd10:   data = SET_MEM_MODE;
      5'd11:   data = 8'h00;
      5'd12:   data = SEG_REMAP;
      5'd13:   data = COM_SCAN_DEC;
      5'd14:   data = SET_COM_PINS;
      5'd15:   data = 8'h12;
      5'd16:   data = SET_CONTRAST;
      5'd17:   data = 8'hCF;
      5'd18:   data = SET_PRECHARGE;
      5'd19:   data = 8'hF1;
      5'd20:   data = SET_VCOM_DESEL;
      5'd21:   data = 8'h40;
      5'd22:   data = DISP_RESUME;
      5'd23:   data = NORM_DISP;
      5'd24:   data = DISP_ON;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/ssd1306_frame_seq.sv
// SSD1306 command/data sequencer: power-on wait, init list, then full-frame
// refreshes streamed from a synchronous framebuffer into the I2C byte master.
module ssd1306_frame_seq
  import ssd1306_pkg::*;
#(
  parameter int POR_CYCLES = 50000,
  parameter int INIT_LEN   = ssd1306_pkg::INIT_LEN,
  parameter int NUM_COLS   = 128,
  parameter int NUM_PAGES  = 8,
  parameter int FB_AW      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refresh_req,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_rdata,
  output logic             i2c_start,
  output logic [7:0]       i2c_data,
  output logic             i2c_is_cmd,
  input  logic             i2c_busy,
  output logic             init_done,
  output logic             frame_busy,
  output logic             frame_done
);

  localparam int               POR_W     = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam logic [POR_W-1:0] POR_LAST  = POR_W'(POR_CYCLES - 1);
  localparam logic [4:0]       INIT_LAST = 5'(INIT_LEN - 1);
  localparam logic [2:0]       WIN_LAST  = 3'(WIN_LEN - 1);
  localparam logic [7:0]       LAST_COL  = 8'(NUM_COLS - 1);
  localparam logic [7:0]       LAST_PAGE = 8'(NUM_PAGES - 1);
  localparam logic [FB_AW-1:0] BYTE_LAST = '1;

  seq_state_e       state_q, state_d;
  hs_phase_e        hs_q, hs_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic [4:0]       init_idx_q, init_idx_d;
  logic [2:0]       win_idx_q, win_idx_d;
  logic [FB_AW-1:0] byte_cnt_q, byte_cnt_d;
  logic             pending_q, pending_d;
  logic             i2c_start_q, i2c_start_d;
  logic [7:0]       i2c_data_q, i2c_data_d;
  logic             i2c_is_cmd_q, i2c_is_cmd_d;
  logic             init_done_q, init_done_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;

  logic [7:0]       rom_byte;
  logic             byte_end;

  ssd1306_init_rom u_init_rom (
    .idx  (init_idx_q),
    .data (rom_byte)
  );

  always_comb begin
    state_d      = state_q;
    hs_d         = hs_q;
    por_cnt_d    = por_cnt_q;
    init_idx_d   = init_idx_q;
    win_idx_d    = win_idx_q;
    byte_cnt_d   = byte_cnt_q;
    pending_d    = pending_q | refresh_req;
    i2c_start_d  = i2c_start_q;
    i2c_data_d   = i2c_data_q;
    i2c_is_cmd_d = i2c_is_cmd_q;
    init_done_d  = init_done_q;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    byte_end     = 1'b0;

    // One handshake engine serves every byte-sending state; the state case
    // below only chooses the byte and what happens after the busy fall.
    if (state_q inside {ST_INIT, ST_WIN, ST_SEND}) begin
      unique case (hs_q)
        HS_ISSUE: begin
          i2c_start_d = 1'b1;
          hs_d        = HS_ACK;
        end
        HS_ACK: begin
          if (i2c_busy) begin
            i2c_start_d = 1'b0;
            hs_d        = HS_DONE;
          end
        end
        HS_DONE: begin
          if (!i2c_busy) begin
            hs_d     = HS_ISSUE;
            byte_end = 1'b1;
          end
        end
        default: hs_d = HS_ISSUE;
      endcase
    end

    unique case (state_q)
      ST_POR_WAIT: begin
        if (por_cnt_q == POR_LAST) begin
          por_cnt_d = '0;
          state_d   = ST_INIT;
        end else begin
          por_cnt_d = por_cnt_q + POR_W'(1);
        end
      end

      ST_INIT: begin
        if (hs_q == HS_ISSUE) begin
          i2c_data_d   = rom_byte;
          i2c_is_cmd_d = 1'b1;
        end
        if (byte_end) begin
          if (init_idx_q == INIT_LAST) begin
            init_idx_d  = '0;
            init_done_d = 1'b1;
            state_d     = ST_READY;
          end else begin
            init_idx_d = init_idx_q + 5'd1;
          end
        end
      end

      ST_READY: begin
        if (pending_q) begin
          // A request landing in the acceptance cycle stays pending.
          pending_d    = refresh_req;
          frame_busy_d = 1'b1;
          state_d      = ST_WIN;
        end
      end

      ST_WIN: begin
        if (hs_q == HS_ISSUE) begin
          i2c_data_d   = win_byte(win_idx_q, LAST_COL, LAST_PAGE);
          i2c_is_cmd_d = 1'b1;
        end
        if (byte_end) begin
          if (win_idx_q == WIN_LAST) begin
            win_idx_d = '0;
            state_d   = ST_FETCH;
          end else begin
            win_idx_d = win_idx_q + 3'd1;
          end
        end
      end

      // fb_addr follows byte_cnt_q, so the RAM sees it during FETCH.
      ST_FETCH: state_d = ST_LATCH;

      ST_LATCH: begin
        i2c_data_d   = fb_rdata;
        i2c_is_cmd_d = 1'b0;
        state_d      = ST_SEND;
      end

      ST_SEND: begin
        if (byte_end) begin
          if (byte_cnt_q == BYTE_LAST) begin
            state_d = ST_FDONE;
          end else begin
            byte_cnt_d = byte_cnt_q + FB_AW'(1);
            state_d    = ST_FETCH;
          end
        end
      end

      ST_FDONE: begin
        frame_done_d = 1'b1;
        frame_busy_d = 1'b0;
        byte_cnt_d   = '0;
        state_d      = ST_READY;
      end

      default: state_d = ST_POR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_POR_WAIT;
      hs_q         <= HS_ISSUE;
      por_cnt_q    <= '0;
      init_idx_q   <= '0;
      win_idx_q    <= '0;
      byte_cnt_q   <= '0;
      pending_q    <= 1'b0;
      i2c_start_q  <= 1'b0;
      i2c_data_q   <= 8'h00;
      i2c_is_cmd_q <= 1'b1;
      init_done_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_d;
      por_cnt_q    <= por_cnt_d;
      init_idx_q   <= init_idx_d;
      win_idx_q    <= win_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      pending_q    <= pending_d;
      i2c_start_q  <= i2c_start_d;
      i2c_data_q   <= i2c_data_d;
      i2c_is_cmd_q <= i2c_is_cmd_d;
      init_done_q  <= init_done_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_addr    = byte_cnt_q;
  assign i2c_start  = i2c_start_q;
  assign i2c_data   = i2c_data_q;
  assign i2c_is_cmd = i2c_is_cmd_q;
  assign init_done  = init_done_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/ssd1306_frame_seq.md
Name: ssd1306_frame_seq

Overview:
Command/data sequencer that sits directly upstream of the SSD1306 I2C byte master and drives its start/data/is_cmd/busy interface.
- After power-up it issues the SSD1306 init command list, then idles.
- On each refresh request it sends the address-window commands, then streams one full frame from a synchronous framebuffer RAM, one byte per I2C transaction.

Parameters:
- POR_CYCLES, 50000: clk cycles to wait after reset release before the first init byte (1 ms at 50 MHz).
- INIT_LEN, 25: number of init command bytes in the ROM.
- NUM_COLS, 128: display columns.
- NUM_PAGES, 8: display pages (8 rows each).
- FB_AW, 10: framebuffer address width; NUM_COLS*NUM_PAGES must equal 2^FB_AW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- refresh_req  in  1  single-cycle pulse requesting a full-frame update.
- fb_addr  out  FB_AW  framebuffer read address; byte index = page*NUM_COLS + col.
- fb_rdata  in  8  framebuffer read data, valid 1 cycle after fb_addr.
- i2c_start  out  1  byte-transaction request to the I2C master.
- i2c_data  out  8  byte to send.
- i2c_is_cmd  out  1  1 = command byte, 0 = GDDRAM data byte.
- i2c_busy  in  1  I2C master busy.
- init_done  out  1  high once the init list has completed; stays high until reset.
- frame_busy  out  1  high from refresh acceptance until frame completion.
- frame_done  out  1  1-cycle pulse when the last frame byte's transaction ends.

Behaviour:
- Reset values: i2c_start=0, i2c_data=0x00, i2c_is_cmd=1, fb_addr=0, init_done=0, frame_busy=0, frame_done=0, pending flag=0, all counters=0, state=POR_WAIT.
- Byte handshake, used for every byte:
  - ISSUE: drive i2c_data and i2c_is_cmd, and assert i2c_start.
  - ACK: hold i2c_start=1 until i2c_busy=1 is sampled, then drop i2c_start.
  - DONE: wait for i2c_busy=0.
  - i2c_data and i2c_is_cmd stay stable from ISSUE through DONE, because the master latches the data byte late in its transaction.
  - The master acknowledges only on its own divider tick, so ACK may last up to CLK_DIV+1 cycles. No timeout.
- States:
  - POR_WAIT: count POR_CYCLES, then go to INIT.
  - INIT: for index 0..INIT_LEN-1, send the ROM byte with is_cmd=1 using the handshake. After the final DONE, set init_done=1 and go to READY.
  - READY: if the pending flag is set, clear it, set frame_busy=1 and go to WIN.
  - WIN: send 6 command bytes: 0x21, 0x00, NUM_COLS-1, 0x22, 0x00, NUM_PAGES-1.
  - FETCH: present fb_addr = byte counter and wait 1 cycle.
  - LATCH: register fb_rdata into i2c_data.
  - SEND: handshake with is_cmd=0. Then, if the byte counter equals 2^FB_AW-1, go to FDONE; otherwise increment the counter and return to FETCH.
  - FDONE: pulse frame_done, clear frame_busy, reset the byte counter to 0, go to READY.
- refresh_req handling:
  - A pulse in any state sets the pending flag, including before init_done and mid-frame.
  - Multiple pulses before service collapse into one pending frame.
  - A pulse during a frame causes exactly one further frame after FDONE.
- Byte counter is FB_AW bits; it never wraps within a frame.
- Reset mid-operation drops i2c_start immediately and restarts at POR_WAIT, re-running the full init list.
- Init ROM content, in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- Per-frame cost: 6 + 2^FB_AW byte transactions (1030 at defaults).

Decomposition:
- Shared package ssd1306_pkg holds:
  - the SSD1306 command constants (DISP_OFF, SET_COL_ADDR=0x21, SET_PAGE_ADDR=0x22, CHARGE_PUMP, DISP_ON, …);
  - the INIT_LEN constant;
  - the state enum.
- Sub-module ssd1306_init_rom: combinational index-to-byte case ROM, 5-bit index, 8-bit data.

Test Plan:
- Reset release with an I2C master model that acks after 250 cycles → first i2c_start rises at cycle POR_CYCLES (±1). The 25 captured bytes match the ROM list with is_cmd=1, and init_done rises after the 25th busy fall.
- refresh_req after init, framebuffer pattern = addr[7:0] → 6 command bytes 21 00 7F 22 00 07 (is_cmd=1), then 1024 data bytes 00,01,…,FF repeating (is_cmd=0), then a single frame_done pulse with frame_busy low the same cycle.
- refresh_req pulsed 3 times during POR_WAIT → the full init sequence, then exactly one frame, then idle in READY.
- refresh_req at data byte 500 → the first frame completes with 1024 bytes, then a second frame follows with the window commands resent.
- Master model holds busy low for 600 cycles after start → i2c_start is held high the whole time, no byte is duplicated or skipped, and i2c_data stays stable until the busy fall.
- rst_n asserted at data byte 300 → i2c_start=0 and frame_busy=0 immediately. After release: POR wait, 25 init bytes, no frame until a new refresh_req.
